// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M iterative multiply/divide unit.
// Opcode and state encodings, special-case divide constants, sign helper.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    localparam logic [MD_XLEN-1:0] MD_DIV0_QUOT = {MD_XLEN{1'b1}};
    localparam logic [MD_XLEN-1:0] MD_OVF_QUOT  =
        {1'b1, {(MD_XLEN-1){1'b0}}};

    // Two's-complement negate when sign is set, pass-through otherwise.
    function automatic logic [MD_XLEN-1:0] negate_if(
        input logic               sign,
        input logic [MD_XLEN-1:0] value
    );
        return sign ? (~value + MD_XLEN'(1)) : value;
    endfunction

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply, restoring divide, one shared accumulator.
module execute_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = MD_XLEN,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [2:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [4:0]       RD_E,
    input  logic             FlushE,
    output logic             StallMD,
    output logic             DoneMD,
    output logic [WIDTH-1:0] ResultMD,
    output logic [4:0]       RD_MD
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN =
        {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        r_state;
    md_op_t           r_op;
    logic [CW-1:0]    r_cnt;
    logic [W2-1:0]    r_acc;
    logic [WIDTH-1:0] r_opnd;
    logic [4:0]       r_rd;
    logic             r_neg;
    logic             r_div0;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_rd_md;

    logic             w_is_div;
    logic             w_is_rem;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_neg;
    logic             w_div0;
    logic             w_ovf;
    logic             w_early;
    logic [WIDTH-1:0] w_early_res;

    logic [WIDTH:0]   w_mul_sum;
    logic [W2-1:0]    w_mul_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [W2-1:0]    w_div_nxt;
    logic [W2-1:0]    w_acc_nxt;

    logic [W2-1:0]    w_prod_s;
    logic [WIDTH-1:0] w_quot_s;
    logic [WIDTH-1:0] w_rem_s;
    logic [WIDTH-1:0] w_calc_res;

    assign StallMD  = rst & StartE & ~FlushE & (r_state != ST_DONE);
    assign DoneMD   = r_done;
    assign ResultMD = r_result;
    assign RD_MD    = r_rd_md;

    // Decode the incoming op: operand signedness, magnitudes, result sign.
    always_comb begin
        w_is_div   = OpE[2];
        w_is_rem   = OpE[2] & OpE[1];
        w_a_signed = w_is_div ? ~OpE[0] : (OpE[1:0] != 2'b11);
        w_b_signed = w_is_div ? ~OpE[0] : ~OpE[1];
        w_sa       = w_a_signed & SrcAE[WIDTH-1];
        w_sb       = w_b_signed & SrcBE[WIDTH-1];
        w_mag_a    = negate_if(w_sa, SrcAE);
        w_mag_b    = negate_if(w_sb, SrcBE);
        w_neg      = w_is_rem ? w_sa : (w_sa ^ w_sb);
        w_div0     = w_is_div & (SrcBE == '0);
        w_ovf      = w_is_div & ~OpE[0] & (SrcAE == INT_MIN)
                   & (SrcBE == {WIDTH{1'b1}});
        w_early    = EARLY_OUT & (w_div0 | w_ovf);
        if (w_is_rem) begin
            w_early_res = w_div0 ? SrcAE : '0;
        end else begin
            w_early_res = w_div0 ? MD_DIV0_QUOT : MD_OVF_QUOT;
        end
    end

    // One radix-2 step of either the multiply or the restoring divide.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]}
                  + {1'b0, (r_acc[0] ? r_opnd : '0)};
        w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_rem_sh  = r_acc[W2-1:WIDTH-1];
        w_diff    = w_rem_sh - {1'b0, r_opnd};
        if (w_diff[WIDTH]) begin
            w_div_nxt = {r_acc[W2-2:0], 1'b0};
        end else begin
            w_div_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
        w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
    end

    // Sign-correct the final step and pick the architectural result.
    always_comb begin
        w_prod_s = r_neg ? (~w_acc_nxt + W2'(1)) : w_acc_nxt;
        w_quot_s = r_div0 ? MD_DIV0_QUOT
                          : negate_if(r_neg, w_acc_nxt[WIDTH-1:0]);
        w_rem_s  = negate_if(r_neg, w_acc_nxt[W2-1:WIDTH]);
        case (r_op)
            OP_MUL:    w_calc_res = w_prod_s[WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_calc_res = w_prod_s[W2-1:WIDTH];
            OP_DIV,
            OP_DIVU:   w_calc_res = w_quot_s;
            default:   w_calc_res = w_rem_s;
        endcase
    end

    // Control FSM plus shared accumulator, counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_md  <= '0;
        end else begin
            r_done <= 1'b0;
            if (FlushE) begin
                r_state <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (StartE) begin
                            r_op   <= md_op_t'(OpE);
                            r_rd   <= RD_E;
                            r_neg  <= w_neg;
                            r_div0 <= w_div0;
                            r_cnt  <= '0;
                            r_opnd <= w_is_div ? w_mag_b : w_mag_a;
                            r_acc  <= {{WIDTH{1'b0}},
                                       (w_is_div ? w_mag_a : w_mag_b)};
                            if (w_early) begin
                                r_state  <= ST_DONE;
                                r_done   <= 1'b1;
                                r_result <= w_early_res;
                                r_rd_md  <= RD_E;
                            end else begin
                                r_state <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        r_acc <= w_acc_nxt;
                        if (r_cnt == CNT_LAST) begin
                            r_cnt    <= '0;
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_calc_res;
                            r_rd_md  <= r_rd;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit: directed RV32M cases,
// flush and reset scenarios, then random ops against a reference model.
module tb_execute_muldiv_unit;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        StartE = 1'b0;
    logic [2:0]  OpE = 3'b000;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic [4:0]  RD_E = '0;
    logic        FlushE = 1'b0;
    logic        StallMD;
    logic        DoneMD;
    logic [31:0] ResultMD;
    logic [4:0]  RD_MD;

    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];

    execute_muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .StartE   (StartE),
        .OpE      (OpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .RD_E     (RD_E),
        .FlushE   (FlushE),
        .StallMD  (StallMD),
        .DoneMD   (DoneMD),
        .ResultMD (ResultMD),
        .RD_MD    (RD_MD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // RV32M semantics computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        longint      p;
        logic [63:0] pv;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 0;
        case (op)
            3'b000: p = sa * sb;
            3'b001: p = sa * sb;
            3'b010: p = sa * ub;
            3'b011: p = ua * ub;
            3'b100: p = (b == 0) ? -1 : (ovf ? sa : sa / sb);
            3'b101: p = (b == 0) ? -1 : ua / ub;
            3'b110: p = (b == 0) ? sa : (ovf ? 0 : sa % sb);
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        pv = p;
        if (op == 3'b001 || op == 3'b010 || op == 3'b011)
            return pv[63:32];
        return pv[31:0];
    endfunction

    function automatic int lat_of(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000
                                 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pop and compare whenever the unit signals a result.
    always @(negedge clk) begin
        if (rst && DoneMD) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done res=%h rd=%0d", ResultMD,
                         RD_MD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", ResultMD, e.res);
                chk("rd", 32'(RD_MD), 32'(e.rd));
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        StartE = 1'b1;
        OpE    = op;
        SrcAE  = a;
        SrcBE  = b;
        RD_E   = rd;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        e.res = ref_md(op, a, b);
        e.rd  = rd;
        sb_q.push_back(e);
        drive(op, a, b, rd);
    endtask

    // Count cycles from issue to DoneMD and check the stall profile.
    task automatic wait_done(input int lat);
        int at;
        logic stall_bad;
        at = -1;
        stall_bad = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (DoneMD) begin
                at = c;
                chk("stall_in_done", 32'(StallMD), 32'd0);
                break;
            end else if (StallMD !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        chk("latency", 32'(at), 32'(lat));
        chk("stall_busy", 32'(stall_bad), 32'd0);
        @(posedge clk);
        #1;
        StartE = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        @(posedge clk);
        #1;
        issue(op, a, b, rd);
        wait_done(lat_of(op, a, b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        StartE = 1'b1;
        #1;
        chk("rst_stall", 32'(StallMD), 32'd0);
        chk("rst_done", 32'(DoneMD), 32'd0);
        chk("rst_result", ResultMD, 32'd0);
        chk("rst_rd", 32'(RD_MD), 32'd0);
        StartE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run_op(3'b101, 32'd100, 32'd7, 5'd9);
        run_op(3'b111, 32'd100, 32'd7, 5'd10);
        run_op(3'b101, 32'h1234, 32'd0, 5'd11);
        run_op(3'b111, 32'h1234, 32'd0, 5'd12);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd15);

        @(posedge clk);
        #1;
        drive(3'b000, 32'd123, 32'd456, 5'd16);
        repeat (10) @(posedge clk);
        #1;
        FlushE = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(StallMD), 32'd0);
        chk("flush_done", 32'(DoneMD), 32'd0);
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        issue(3'b001, 32'h7654_3210, 32'h89AB_CDEF, 5'd17);
        wait_done(33);

        @(posedge clk);
        #1;
        drive(3'b100, 32'd1000, 32'd3, 5'd18);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(StallMD), 32'd0);
        chk("mid_rst_done", 32'(DoneMD), 32'd0);
        chk("mid_rst_result", ResultMD, 32'd0);
        chk("mid_rst_rd", 32'(RD_MD), 32'd0);
        StartE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (DoneMD) dcount++;
        end
        chk("idle_after_rst", 32'(dcount), 32'd0);

        for (int n = 0; n < 60; n++) begin
            run_op(3'($urandom_range(0, 7)), rand_val(), rand_val(),
                   5'($urandom_range(0, 31)));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
